// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op and mthilo encodings, the FSM state enum and op decode helpers.
package mdu_pkg;

  localparam logic [3:0] MDU_MULTU = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_DIVU  = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_MADDU = 4'b0100;
  localparam logic [3:0] MDU_MADD  = 4'b0101;
  localparam logic [3:0] MDU_MSUBU = 4'b0110;
  localparam logic [3:0] MDU_MSUB  = 4'b0111;

  localparam logic [1:0] MTHILO_LO = 2'b00;
  localparam logic [1:0] MTHILO_HI = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DFIX} mdu_state_e;

  typedef enum logic [1:0] {OPC_MUL, OPC_DIV, OPC_MADD, OPC_MSUB} op_class_e;

  // Operation family; op[3]=1 no-ops are screened out before this is used.
  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e c;
    c = OPC_MUL;
    case (op)
      MDU_MULTU, MDU_MULT: c = OPC_MUL;
      MDU_DIVU,  MDU_DIV:  c = OPC_DIV;
      MDU_MADDU, MDU_MADD: c = OPC_MADD;
      MDU_MSUBU, MDU_MSUB: c = OPC_MSUB;
      default:             c = OPC_MUL;
    endcase
    return c;
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue-side bundle of the multiply/divide unit.
// master: issue stage (drives start/op/operands/mthilo/cancel, sees hi/lo/busy/done).
// slave:  mul_div_unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       mthilo;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, src_a, src_b, mthilo, cancel,
                  input  hi, lo, busy, done);
  modport slave  (input  start, op, src_a, src_b, mthilo, cancel,
                  output hi, lo, busy, done);
endinterface

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider on operand magnitudes.
// Ports: clk, reset (async, active-low); start_i/cancel_i load or abort;
// signed_i, dividend_i, divisor_i operands; busy_o while iterating;
// valid_o once all WIDTH quotient bits exist; quo_o_c/rem_o_c are the
// sign-corrected results (divide-by-zero override applied).
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quo_o_c,
  output logic [WIDTH-1:0] rem_o_c
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             busy_q, busy_d, valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic             negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;

  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   shift_c, diff_c;

  // Magnitudes: a most-negative operand maps to 2^(WIDTH-1) as unsigned.
  assign a_neg_c = signed_i & dividend_i[WIDTH-1];
  assign b_neg_c = signed_i & divisor_i[WIDTH-1];
  assign a_mag_c = a_neg_c ? -dividend_i : dividend_i;
  assign b_mag_c = b_neg_c ? -divisor_i  : divisor_i;

  // One restoring step: bring down the next dividend bit, trial subtract.
  assign shift_c = {rem_q, quo_q[WIDTH-1]};
  assign diff_c  = shift_c - {1'b0, dvs_q};

  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    if (cancel_i) begin
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else if (start_i) begin
      busy_d  = 1'b1;
      valid_d = 1'b0;
      cnt_d   = CNT_W'(WIDTH);
      quo_d   = a_mag_c;
      rem_d   = '0;
      dvs_d   = b_mag_c;
      dvd_d   = dividend_i;
      negq_d  = a_neg_c ^ b_neg_c;
      negr_d  = a_neg_c;
      zero_d  = (divisor_i == '0);
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (!diff_c[WIDTH]) begin
        rem_d = diff_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shift_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q == CNT_W'(1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  // Sign fix; divide-by-zero returns all-ones quotient and the raw dividend.
  assign quo_o_c = zero_q ? '1    : (negq_q ? -quo_q : quo_q);
  assign rem_o_c = zero_q ? dvd_q : (negr_q ? -rem_q : rem_q);

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit beside the EX-stage ALU.
// Ports: clk, reset (async, active-low) and bus (slave modport): start/op/
// src_a/src_b issue an op, mthilo writes HI/LO directly, cancel aborts the
// in-flight op; hi/lo architectural registers, busy while an op is in
// flight, done one-cycle pulse when a completed op updated HI/LO.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int unsigned W2      = 2 * WIDTH;
  localparam int unsigned CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    tmp_q, tmp_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             accept_c;
  op_class_e        cls_c;
  logic [W2-1:0]    ext_a_c, ext_b_c, prod_c, mac_c;
  logic             div_busy, div_valid;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign accept_c = (state_q == ST_IDLE) && bus.start && !bus.op[3] && !bus.cancel;
  assign cls_c    = op_class(bus.op);

  // Full-width product at acceptance; truncation to 2*WIDTH gives the
  // correct two's-complement result for signed operands too.
  always_comb begin
    if (op_signed(bus.op)) begin
      ext_a_c = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a};
      ext_b_c = {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
    end else begin
      ext_a_c = {{WIDTH{1'b0}}, bus.src_a};
      ext_b_c = {{WIDTH{1'b0}}, bus.src_b};
    end
    prod_c = ext_a_c * ext_b_c;
    case (cls_c)
      OPC_MADD: mac_c = {hi_q, lo_q} + prod_c;
      OPC_MSUB: mac_c = {hi_q, lo_q} - prod_c;
      default:  mac_c = prod_c;
    endcase
  end

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (accept_c && (cls_c == OPC_DIV)),
    .cancel_i   (bus.cancel),
    .signed_i   (op_signed(bus.op)),
    .dividend_i (bus.src_a),
    .divisor_i  (bus.src_b),
    .busy_o     (div_busy),
    .valid_o    (div_valid),
    .quo_o_c    (div_quo),
    .rem_o_c    (div_rem)
  );

  // Next-state, counter and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (cls_c == OPC_DIV) begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MUL_LAT);
            tmp_d   = mac_c;
          end
        end else if (bus.mthilo == MTHILO_LO) begin
          lo_d = bus.src_a;
        end else if (bus.mthilo == MTHILO_HI) begin
          hi_d = bus.src_a;
        end
      end
      ST_MUL: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = tmp_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DFIX;
        end
      end
      ST_DFIX: begin
        state_d = ST_IDLE;
        if (!bus.cancel && div_valid) begin
          hi_d   = div_rem;
          lo_d   = div_quo;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmp_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // The divider core must still be iterating for every DIV-state cycle.
  ap_div_in_step: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_DIV) |-> div_busy);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random ops, scoreboard
// of expected {hi,lo} values checked by an independent done monitor.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int             n_vec = 0;
  int             n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on mathematically extended operands.
  function automatic logic [2*W-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [2*W-1:0] acc);
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] xa, xb, prod;
    logic [W-1:0]          q, r;
    logic [W-1:0]          most_neg, minus_one;
    most_neg  = {1'b1, {(W-1){1'b0}}};
    minus_one = {W{1'b1}};
    sa = a;
    sb = b;
    if (op inside {MDU_MULT, MDU_MADD, MDU_MSUB}) begin
      xa = sa;
      xb = sb;
    end else begin
      xa = {{W{1'b0}}, a};
      xb = {{W{1'b0}}, b};
    end
    prod = xa * xb;
    case (op)
      MDU_MULTU, MDU_MULT: return prod;
      MDU_MADDU, MDU_MADD: return acc + prod;
      MDU_MSUBU, MDU_MSUB: return acc - prod;
      MDU_DIVU: begin
        if (b == 0) return {a, minus_one};
        return {a % b, a / b};
      end
      MDU_DIV: begin
        if (b == 0) return {a, minus_one};
        if (a == most_neg && b == minus_one) return {{W{1'b0}}, most_neg};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: return acc;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
      end else begin
        check("result_hilo", {bus.hi, bus.lo}, exp_q.pop_front());
        check("done_with_busy", 2*W'(bus.busy), '0);
      end
    end
  end

  // Issue one op at the current negedge and wait until busy drops.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] mth = 2'b10);
    logic [2*W-1:0] e;
    int             n;
    int             lat;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.mthilo = mth;
    if (!op[3]) begin
      e = ref_model(op, a, b, {m_hi, m_lo});
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
      lat = (op inside {MDU_DIVU, MDU_DIV}) ? int'(W) + 1 : int'(LAT);
    end else begin
      lat = 0;
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mthilo = 2'b10;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 2*W'(n), 2*W'(lat));
    if (!op[3]) check("done_pulse", 2*W'(bus.done), 2*W'(1));
  endtask

  task automatic mth_write(input logic [1:0] sel, input logic [W-1:0] v);
    bus.mthilo = sel;
    bus.src_a  = v;
    @(negedge clk);
    bus.mthilo = 2'b10;
    if (sel == MTHILO_LO) m_lo = v;
    else                  m_hi = v;
    check("mthilo", {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  // Start an op and cancel it while it is in busy cycle k.
  task automatic cancel_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int k);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (k - 1) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 2*W'(bus.busy), '0);
    check("cancel_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    repeat (3) @(negedge clk);
    check("cancel_hilo_later", {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] rop;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.mthilo = 2'b10;
    bus.cancel = 1'b0;
    m_hi       = '0;
    m_lo       = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, '0);
    check("reset_busy_done", 2*W'({bus.busy, bus.done}), '0);
    reset = 1'b1;
    @(negedge clk);

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg2x3", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    mth_write(MTHILO_HI, 32'd0);
    mth_write(MTHILO_LO, 32'd10);
    issue(MDU_MADD, 32'd4, 32'd5);
    check("madd", {bus.hi, bus.lo}, 64'h0000_0000_0000_001E);
    issue(MDU_MSUBU, 32'd2, 32'd20);
    check("msubu", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF6);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(MDU_DIVU, 32'd7, 32'd0);
    check("divu_by_zero", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    issue(MDU_DIV, 32'hFFFF_FFFB, 32'd0);
    check("div_signed_by_zero", {bus.hi, bus.lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    cancel_op(MDU_DIVU, 32'd100, 32'd7, 10);
    cancel_op(MDU_MULTU, 32'd9, 32'd9, 2);
    cancel_op(MDU_DIV, 32'd50, 32'hFFFF_FFFD, int'(W) + 1);

    // Start wins over a same-cycle MTLO.
    issue(MDU_MULTU, 32'd6, 32'd7, MTHILO_LO);
    check("start_over_mtlo", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);

    // A no-op start is ignored.
    issue(4'b1011, 32'd1, 32'd1);

    // Cancel in IDLE drops the start but MTLO still lands.
    bus.start  = 1'b1;
    bus.op     = MDU_MULT;
    bus.cancel = 1'b1;
    bus.mthilo = MTHILO_LO;
    bus.src_a  = 32'h1234_5678;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.mthilo = 2'b10;
    m_lo       = 32'h1234_5678;
    check("idle_cancel_busy", 2*W'(bus.busy), '0);
    check("idle_cancel_mtlo", {bus.hi, bus.lo}, {m_hi, m_lo});

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0)
        mth_write(2'($urandom_range(0, 1)), pick());
      rop = 4'($urandom_range(0, 8));
      if (rop[3]) rop = 4'b1000 | 4'($urandom_range(0, 7));
      issue(rop, pick(), pick());
    end

    // Asynchronous reset between edges mid-multiply.
    mth_write(MTHILO_HI, 32'hDEAD_BEEF);
    bus.start = 1'b1;
    bus.op    = MDU_MADDU;
    bus.src_a = 32'd3;
    bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("async_reset_hilo", {bus.hi, bus.lo}, '0);
    check("async_reset_busy", 2*W'({bus.busy, bus.done}), '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_hilo", {bus.hi, bus.lo}, '0);

    issue(MDU_MSUB, 32'd5, 32'hFFFF_FFFF);
    check("post_reset_msub", {bus.hi, bus.lo}, 64'h0000_0000_0000_0005);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 2*W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
